// File: rtl/traffic_display_scanner_pkg.sv
// traffic_disp_pkg: shared constants for the traffic display scanner.
//   - 7-segment glyphs, bit order {g,f,e,d,c,b,a}, active-high
//   - slot index encoding in scan order A_L, A_H, B_L, B_H
//   - one-hot anode patterns and a slot-to-anode helper
package traffic_disp_pkg;

    typedef logic [1:0] slot_t;

    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_DASH  = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    localparam slot_t SLOT_AL = 2'd0;
    localparam slot_t SLOT_AH = 2'd1;
    localparam slot_t SLOT_BL = 2'd2;
    localparam slot_t SLOT_BH = 2'd3;

    localparam logic [3:0] AN_OFF = 4'b0000;
    localparam logic [3:0] AN_AL  = 4'b0001;
    localparam logic [3:0] AN_AH  = 4'b0010;
    localparam logic [3:0] AN_BL  = 4'b0100;
    localparam logic [3:0] AN_BH  = 4'b1000;

    function automatic logic [3:0] slot_an(slot_t s);
        logic [3:0] an;
        an = AN_OFF;
        unique case (s)
            SLOT_AL: an = AN_AL;
            SLOT_AH: an = AN_AH;
            SLOT_BL: an = AN_BL;
            SLOT_BH: an = AN_BH;
            default: an = AN_OFF;
        endcase
        return an;
    endfunction

endpackage

// File: rtl/traffic_display_scanner_if.sv
// traffic_display_scanner_if: bundle between the traffic controller side and the scanner.
//   Controller side : A_Time_L/H, B_Time_L/H (BCD), A_Light, B_Light
//   Display side    : SEG[6:0], AN[3:0], A_Red, A_Green, B_Red, B_Green, FAULT
//   master = producer of times/lights and consumer of display drives; slave = the scanner.
interface traffic_display_scanner_if;
    logic [3:0] A_Time_L;
    logic [3:0] A_Time_H;
    logic [3:0] B_Time_L;
    logic [3:0] B_Time_H;
    logic       A_Light;
    logic       B_Light;
    logic [6:0] SEG;
    logic [3:0] AN;
    logic       A_Red;
    logic       A_Green;
    logic       B_Red;
    logic       B_Green;
    logic       FAULT;

    modport master (
        output A_Time_L, A_Time_H, B_Time_L, B_Time_H, A_Light, B_Light,
        input  SEG, AN, A_Red, A_Green, B_Red, B_Green, FAULT
    );

    modport slave (
        input  A_Time_L, A_Time_H, B_Time_L, B_Time_H, A_Light, B_Light,
        output SEG, AN, A_Red, A_Green, B_Red, B_Green, FAULT
    );
endinterface

// File: rtl/traffic_display_scanner_decoder.sv
// bcd_seg_decoder: combinational BCD digit to 7-segment glyph.
//   digit [3:0] in  : BCD value; 10..15 render as a dash
//   blank       in  : forces all segments off
//   seg   [6:0] out : {g,f,e,d,c,b,a}, active-high
module bcd_seg_decoder
    import traffic_disp_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);
    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (digit)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_DASH;
            endcase
        end
    end
endmodule

// File: rtl/traffic_display_scanner.sv
// traffic_display_scanner: 4-digit multiplexed 7-segment scanner plus road lamps.
//   CLK  in  : system clock
//   R    in  : synchronous reset, active-high
//   bus  slave modport of traffic_display_scanner_if:
//        times/lights in; SEG, AN, lamps, FAULT out (all registered)
// Digits are shadowed at each frame start (slot 0), high digits of 0 are blanked,
// the green road blinks when its remaining time is 1..BLINK_THRESH, and a green/green
// conflict latches FAULT and forces both roads red until reset.
module traffic_display_scanner
    import traffic_disp_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 1000,
    parameter int unsigned GUARD        = 2,
    parameter int unsigned BLINK_FRAMES = 64,
    parameter int unsigned BLINK_THRESH = 3
) (
    input logic                     CLK,
    input logic                     R,
    traffic_display_scanner_if.slave bus
);
    localparam logic [15:0] DIV_MAX = 16'(SCAN_DIV - 1);

    logic [15:0]      div_q, div_d;
    slot_t            slot_q, slot_d;
    logic [7:0]       frame_q, frame_d;
    logic             phase_q, phase_d;
    logic [3:0][3:0]  digits_q, digits_d;  // index = slot: A_L, A_H, B_L, B_H
    logic [6:0]       seg_q, seg_d;
    logic [3:0]       an_q, an_d;
    logic             a_red_q, a_green_q, b_red_q, b_green_q, fault_q;
    logic             a_red_d, a_green_d, b_red_d, b_green_d, fault_d;

    logic             wrap, frame_start;
    logic [3:0]       grp_hi, grp_lo, dec_digit;
    logic [6:0]       grp_val, dec_seg;
    logic             grp_light, blink_dark, dec_blank;

    // Everything below looks at the slot being entered (slot_d) with the
    // freshly loaded shadows and updated phase, so simultaneous events agree.
    always_comb begin
        wrap        = (div_q == DIV_MAX);
        div_d       = wrap ? 16'd0 : div_q + 16'd1;
        slot_d      = wrap ? slot_q + 2'd1 : slot_q;
        frame_start = wrap && (slot_q == SLOT_BH);
        digits_d    = digits_q;
        frame_d     = frame_q;
        phase_d     = phase_q;
        if (frame_start) begin
            digits_d = {bus.B_Time_H, bus.B_Time_L, bus.A_Time_H, bus.A_Time_L};
            if (({1'b0, frame_q} + 9'd1) == 9'(BLINK_FRAMES)) begin
                frame_d = 8'd0;
                phase_d = ~phase_q;
            end else begin
                frame_d = frame_q + 8'd1;
            end
        end

        grp_lo     = digits_d[{slot_d[1], 1'b0}];
        grp_hi     = digits_d[{slot_d[1], 1'b1}];
        grp_light  = slot_d[1] ? bus.B_Light : bus.A_Light;
        grp_val    = {grp_hi, 3'b000} + {2'b00, grp_hi, 1'b0} + {3'b000, grp_lo};
        blink_dark = grp_light && (grp_hi <= 4'd9) && (grp_lo <= 4'd9) &&
                     (grp_val != 7'd0) && (grp_val <= 7'(BLINK_THRESH)) && phase_d;

        dec_digit = digits_d[slot_d];
        dec_blank = slot_d[0] && (dec_digit == 4'd0);
        seg_d     = wrap ? dec_seg : seg_q;

        an_d = an_q;
        if (wrap) begin
            an_d = AN_OFF;
        end
        // GUARD = 0 lands on the wrap edge and overrides the blanking above.
        if (div_d == 16'(GUARD)) begin
            an_d = blink_dark ? AN_OFF : slot_an(slot_d);
        end

        fault_d   = fault_q | (bus.A_Light & bus.B_Light);
        a_green_d = ~fault_d & bus.A_Light;
        a_red_d   = fault_d | ~bus.A_Light;
        b_green_d = ~fault_d & bus.B_Light;
        b_red_d   = fault_d | ~bus.B_Light;
    end

    bcd_seg_decoder u_dec (
        .digit (dec_digit),
        .blank (dec_blank),
        .seg   (dec_seg)
    );

    always_ff @(posedge CLK) begin
        if (R) begin
            div_q     <= DIV_MAX;
            slot_q    <= SLOT_BH;
            frame_q   <= 8'd0;
            phase_q   <= 1'b0;
            digits_q  <= '0;
            seg_q     <= SEG_BLANK;
            an_q      <= AN_OFF;
            a_red_q   <= 1'b0;
            a_green_q <= 1'b0;
            b_red_q   <= 1'b0;
            b_green_q <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            div_q     <= div_d;
            slot_q    <= slot_d;
            frame_q   <= frame_d;
            phase_q   <= phase_d;
            digits_q  <= digits_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
            a_red_q   <= a_red_d;
            a_green_q <= a_green_d;
            b_red_q   <= b_red_d;
            b_green_q <= b_green_d;
            fault_q   <= fault_d;
        end
    end

    assign bus.SEG     = seg_q;
    assign bus.AN      = an_q;
    assign bus.A_Red   = a_red_q;
    assign bus.A_Green = a_green_q;
    assign bus.B_Red   = b_red_q;
    assign bus.B_Green = b_green_q;
    assign bus.FAULT   = fault_q;
endmodule

// File: doc/traffic_display_scanner.md
Name: traffic_display_scanner

Overview:
- Downstream consumer of the traffic light controller top.
- Takes the four BCD countdown digits and the two light bits, and drives one 4-digit multiplexed 7-segment display plus discrete red/green lamps for each road.
- Shadows the digits once per scan frame, blanks leading zeros, blinks the running-out green road, and latches a fault on a green/green conflict.

Parameters:
- SCAN_DIV, 1000: CLK cycles per digit slot; legal range 2..65535.
- GUARD, 2: cycles at the start of each slot with all anodes off (anti-ghosting); legal range 0..SCAN_DIV-1.
- BLINK_FRAMES, 64: frames per blink half-period; legal range 1..255.
- BLINK_THRESH, 3: remaining seconds at or below which the green road's digits blink; legal range 0..99.

Ports:
- CLK  in  1  system clock
- R  in  1  synchronous reset, active-high
- A_Time_L  in  4  road A seconds, low BCD digit
- A_Time_H  in  4  road A seconds, high BCD digit
- B_Time_L  in  4  road B seconds, low BCD digit
- B_Time_H  in  4  road B seconds, high BCD digit
- A_Light  in  1  1 = road A green, 0 = road A red
- B_Light  in  1  1 = road B green, 0 = road B red
- SEG  out  7  segments {g,f,e,d,c,b,a}, active-high
- AN  out  4  one-hot digit enable, active-high; bit0 = A_L, bit1 = A_H, bit2 = B_L, bit3 = B_H
- A_Red, A_Green, B_Red, B_Green  out  1 each  lamp drives
- FAULT  out  1  sticky green/green conflict flag

Behaviour:
- All outputs registered.
- Reset values:
  - SEG = 0, AN = 0000, all lamps 0, FAULT = 0.
  - Internal: slot index = 3, divider = SCAN_DIV-1, frame counter = 0, blink phase = 0 (digits visible).
- Slot timing:
  - Divider counts 0..SCAN_DIV-1 and wraps.
  - On wrap, slot index advances mod 4 in the order A_L, A_H, B_L, B_H.
  - The first edge with R low is therefore the start of slot 0.
- Frame load: at every slot-0 start edge, all four digit shadows load from the inputs.
  - SEG on that same edge is computed from the values being loaded.
  - Input changes mid-frame are invisible until the next frame.
- Per slot:
  - At the slot start edge, SEG is updated and AN = 0000.
  - At the edge where the divider reaches GUARD, AN = one-hot(slot).
  - With GUARD = 0, AN asserts on the slot start edge.
- Decoding:
  - BCD 0..9 maps to standard glyphs.
  - Values 10..15 display dash (g only).
  - A high digit equal to 0 is blanked (SEG = 0, AN still asserted).
  - A low digit is never blanked.
- Blink:
  - The frame counter increments at each slot-0 start.
  - On reaching BLINK_FRAMES it clears and toggles the blink phase.
  - A road's group blinks when all of the following hold:
    - its light input is 1;
    - both shadow digits are valid BCD;
    - 1 <= H*10+L <= BLINK_THRESH.
  - While the group blinks and phase = 1, AN stays 0000 for that group's slots; SEG is still updated.
  - A value of 0 never blinks.
- Lamps: registered one cycle after input.
  - A_Green = A_Light, A_Red = ~A_Light; same for road B.
- Conflict: when A_Light & B_Light = 1 on any cycle, the next edge gives:
  - all greens = 0, both reds = 1, FAULT = 1.
  - Lamps stay forced to red/red while FAULT = 1.
  - FAULT clears only on R.
- Reset mid-operation: R on any edge returns every register to its reset value on that edge, overriding all other events.
- Simultaneous events:
  - Divider wrap, frame load and blink toggle on the same edge all take effect together.
  - The blink decision for the new slot uses the newly loaded shadows and the new phase.

Decomposition:
- Package traffic_disp_pkg:
  - 7-bit glyph constants for 0..9, SEG_DASH, SEG_BLANK;
  - slot index encoding constants (SLOT_AL = 0 .. SLOT_BH = 3);
  - one-hot anode constants.
- Sub-module bcd_seg_decoder: combinational 4-bit BCD plus blank flag to 7-bit SEG; instantiated once, fed from the muxed shadow digit.
- Scan/blink counters and lamp/fault logic live in the top of this block.

Test Plan:
- Reset and scan order. Setup: SCAN_DIV=4, GUARD=1, inputs A=27, B=05, A_Light=1, B_Light=0; hold R 3 cycles, release.
  - AN sequence per slot is 0000 then 0001, 0010, 0100, 1000.
  - SEG is 7, 2, 5, blank in turn.
  - A_Green=1, B_Red=1.
- Mid-frame change. Setup: change A_Time_L 7→3 during slot 1.
  - Slot 0 keeps showing 7 until the next frame start, then shows 3.
- Invalid BCD. Setup: B_Time_L=4'hC.
  - SEG=7'b1000000 in slot 2.
  - Road B never blinks even with B_Light=1 and H=0.
- Blink. Setup: BLINK_FRAMES=2, A=02, A_Light=1.
  - A slots toggle AN visible/dark every 2 frames.
  - B slots are always visible.
  - With A=00, no blink.
- Conflict. Setup: A_Light=B_Light=1 for 1 cycle, then A_Light=0.
  - Next edge: all greens 0, both reds 1, FAULT=1.
  - Remains so until R; after R, FAULT=0.
- Reset mid-slot. Setup: assert R while divider=2, slot=2.
  - Same edge: AN=0000, SEG=0.
  - After release, restart at slot 0 with a fresh shadow load.
